// File: rtl/day1a.sv
// Streaming dial-rotation solver: two-stage pipeline that counts rotations ending at position 0.
// Optional macro DAY1A_BAD_OP_CNT_EN adds a saturating bad_op_count output for unknown op bytes.
module day1a #(
  parameter int DIAL_SIZE = 100,
  parameter int START_POS = 50,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_valid,
  input  logic [31:0]      data,
`ifdef DAY1A_BAD_OP_CNT_EN
  output logic [15:0]      bad_op_count,
`endif
  output logic [CNT_W-1:0] answer
);

  localparam int POS_W = (DIAL_SIZE <= 2) ? 1 : $clog2(DIAL_SIZE);
  localparam logic [POS_W:0] DIAL = (POS_W+1)'(DIAL_SIZE);

  logic             w_isL;
  logic             w_isR;
  logic [POS_W-1:0] w_dist;

  logic             r_s1Valid;
  logic             r_s1IsL;
  logic [POS_W-1:0] r_s1Dist;

  logic [POS_W-1:0] r_pos;
  logic [CNT_W-1:0] r_answer;

  logic [POS_W:0]   w_posExt;
  logic [POS_W:0]   w_distExt;
  logic [POS_W:0]   w_sum;
  logic [POS_W-1:0] w_nextPos;

  assign w_isL  = (data[31:24] == 8'h4C);
  assign w_isR  = (data[31:24] == 8'h52);
  // Constant-divisor modulo of the full 24-bit distance, so the result is always < DIAL_SIZE.
  assign w_dist = POS_W'({8'd0, data[23:0]} % 32'(DIAL_SIZE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Valid <= 1'b0;
      r_s1IsL   <= 1'b0;
      r_s1Dist  <= '0;
    end else begin
      r_s1Valid <= data_valid & (w_isL | w_isR);
      r_s1IsL   <= w_isL;
      r_s1Dist  <= w_dist;
    end
  end

  assign w_posExt  = {1'b0, r_pos};
  assign w_distExt = {1'b0, r_s1Dist};
  assign w_sum     = w_posExt + w_distExt;

  // Wrap without negative intermediates: both operands are already below DIAL_SIZE.
  always_comb begin
    w_nextPos = r_pos;
    if (r_s1IsL) begin
      if (r_s1Dist <= r_pos)
        w_nextPos = r_pos - r_s1Dist;
      else
        w_nextPos = POS_W'(w_posExt + DIAL - w_distExt);
    end else begin
      if (w_sum >= DIAL)
        w_nextPos = POS_W'(w_sum - DIAL);
      else
        w_nextPos = POS_W'(w_sum);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos    <= POS_W'(START_POS);
      r_answer <= '0;
    end else if (r_s1Valid) begin
      r_pos <= w_nextPos;
      if (w_nextPos == '0)
        r_answer <= r_answer + 1'b1;
    end
  end

  assign answer = r_answer;

`ifdef DAY1A_BAD_OP_CNT_EN
  logic        r_s1Bad;
  logic [15:0] r_badCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Bad  <= 1'b0;
      r_badCnt <= '0;
    end else begin
      r_s1Bad <= data_valid & ~(w_isL | w_isR);
      if (r_s1Bad && (r_badCnt != 16'hFFFF))
        r_badCnt <= r_badCnt + 16'd1;
    end
  end

  assign bad_op_count = r_badCnt;
`endif

endmodule

// File: tb/tb_day1a.sv
// Self-checking bench for day1a: directed puzzle vectors plus randomized commands
// against an arithmetic dial model with a two-cycle expected-answer queue.
module tb_day1a;

  localparam int DIAL  = 100;
  localparam int START = 50;

  logic        clk;
  logic        rst_n;
  logic        data_valid;
  logic [31:0] data;
  logic [31:0] answer;
`ifdef DAY1A_BAD_OP_CNT_EN
  logic [15:0] bad_op_count;
`endif

  day1a #(.DIAL_SIZE(DIAL), .START_POS(START), .CNT_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_valid  (data_valid),
    .data        (data),
`ifdef DAY1A_BAD_OP_CNT_EN
    .bad_op_count(bad_op_count),
`endif
    .answer      (answer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          mPos;
  logic [31:0] mCnt;
  int          mBad;
  logic [31:0] expQ[$];
  int          badQ[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mPos = START;
    mCnt = 0;
    mBad = 0;
    expQ = '{32'd0, 32'd0};
    badQ = '{0, 0};
  endtask

  // Dial arithmetic straight from the puzzle rules, on plain integers.
  task automatic modelApply(input logic v, input logic [31:0] w);
    int d;
    if (!v) return;
    d = int'(w[23:0]);
    if (w[31:24] == 8'h4C) begin
      mPos = (mPos + DIAL - (d % DIAL)) % DIAL;
      if (mPos == 0) mCnt = mCnt + 1;
    end else if (w[31:24] == 8'h52) begin
      mPos = (mPos + d) % DIAL;
      if (mPos == 0) mCnt = mCnt + 1;
    end else if (mBad < 65535) begin
      mBad = mBad + 1;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] w);
    @(negedge clk);
    checkOutput("answer_stream", answer, expQ.pop_front());
`ifdef DAY1A_BAD_OP_CNT_EN
    checkOutput("bad_op_stream", 32'(bad_op_count), 32'(badQ.pop_front()));
`else
    void'(badQ.pop_front());
`endif
    data_valid = v;
    data       = w;
    modelApply(v, w);
    expQ.push_back(mCnt);
    badQ.push_back(mBad);
  endtask

  task automatic flush();
    applyStimulus(1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0);
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n      = 1'b0;
    data_valid = 1'b0;
    data       = 32'h0;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] seq10[10];
  logic [31:0] w;
  logic        v;

  initial begin
    rst_n      = 1'b0;
    data_valid = 1'b0;
    data       = 32'h0;
    modelReset();
    #12;
    checkOutput("reset_answer", answer, 32'd0);
`ifdef DAY1A_BAD_OP_CNT_EN
    checkOutput("reset_bad_op", 32'(bad_op_count), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] puzzle example sequence");
    seq10 = '{32'h4C000044, 32'h4C00001E, 32'h52000030, 32'h4C000005, 32'h5200003C,
              32'h4C000037, 32'h4C000001, 32'h4C000063, 32'h5200000E, 32'h4C000052};
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, seq10[i]);
    flush();
    checkOutput("seq10_final", answer, 32'd3);

    $display("[TB] R50 then R0 on position 0");
    resetDut();
    applyStimulus(1'b1, 32'h52000032);
    flush();
    checkOutput("r50_answer", answer, 32'd1);
    applyStimulus(1'b1, 32'h52000000);
    flush();
    checkOutput("r0_on_zero", answer, 32'd2);

    $display("[TB] large distances");
    resetDut();
    applyStimulus(1'b1, 32'h4C0F4272);
    flush();
    checkOutput("l1000050", answer, 32'd1);
    applyStimulus(1'b1, 32'h52FFFFFF);
    applyStimulus(1'b1, 32'h52000055);
    flush();
    checkOutput("r_max_then_r85", answer, 32'd2);

    $display("[TB] invalid op interleaved");
    resetDut();
    applyStimulus(1'b1, 32'h52000019);
    applyStimulus(1'b1, 32'h58000032);
    applyStimulus(1'b1, 32'h52000019);
    flush();
    checkOutput("x_ignored", answer, 32'd1);
`ifdef DAY1A_BAD_OP_CNT_EN
    checkOutput("x_bad_count", 32'(bad_op_count), 32'd1);
`endif

    $display("[TB] data_valid toggling with garbage");
    resetDut();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 32'h5200000A);
      applyStimulus(1'b0, $urandom);
    end
    flush();
    checkOutput("toggle_answer", answer, 32'd1);

    $display("[TB] reset mid-stream");
    resetDut();
    applyStimulus(1'b1, 32'h52000032);
    applyStimulus(1'b1, 32'h5200000A);
    applyStimulus(1'b1, 32'h52000028);
    @(negedge clk);
    rst_n      = 1'b0;
    data_valid = 1'b0;
    #1;
    checkOutput("midreset_answer", answer, 32'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h52000032);
    flush();
    checkOutput("after_reset_r50", answer, 32'd1);

    $display("[TB] randomized commands");
    resetDut();
    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      case ($urandom_range(0, 3))
        0: w[31:24] = 8'h4C;
        1: w[31:24] = 8'h52;
        2: w[31:24] = 8'h58;
        default: ;
      endcase
      if ($urandom_range(0, 1) == 0) w[23:0] = 24'($urandom_range(0, 250));
      v = ($urandom_range(0, 3) != 0);
      applyStimulus(v, w);
    end
    flush();
    checkOutput("random_final", answer, mCnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
